// File: rtl/cache_arb_pkg.sv
// Shared channel types and helpers for the CacheBus read-channel arbiter.
// The typedef macros let each instance build structs sized to its own parameters.
`ifndef CACHE_ARB_TYPEDEF_MACROS
`define CACHE_ARB_TYPEDEF_MACROS
`define CACHE_TYPEDEF_AR_CHAN_T(ar_chan_t, addr_t, id_t, user_t) \
  typedef struct packed {                                          \
    id_t         id;                                               \
    addr_t       addr;                                             \
    logic [7:0]  len;                                              \
    logic [2:0]  size;                                             \
    logic [1:0]  burst;                                            \
    user_t       user;                                             \
    logic [3:0]  snoop;                                            \
  } ar_chan_t;
`define CACHE_TYPEDEF_R_CHAN_T(r_chan_t, data_t, id_t, user_t) \
  typedef struct packed {                                      \
    id_t         id;                                           \
    data_t       data;                                         \
    logic [3:0]  resp;                                         \
    logic        last;                                         \
    user_t       user;                                         \
  } r_chan_t;
`endif

package cache_arb_pkg;

  function automatic int idx_w(input int n_mst);
    return (n_mst > 1) ? $clog2(n_mst) : 1;
  endfunction

  localparam int DEF_N_MST      = 2;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ID_WIDTH   = 4;
  localparam int DEF_USER_WIDTH = 1;

  typedef logic [DEF_ADDR_WIDTH-1:0]                    def_addr_t;
  typedef logic [DEF_DATA_WIDTH-1:0]                    def_data_t;
  typedef logic [DEF_ID_WIDTH-1:0]                      def_mst_id_t;
  typedef logic [DEF_ID_WIDTH+idx_w(DEF_N_MST)-1:0]     def_slv_id_t;
  typedef logic [DEF_USER_WIDTH-1:0]                    def_user_t;

  `CACHE_TYPEDEF_AR_CHAN_T(mst_ar_chan_t, def_addr_t, def_mst_id_t, def_user_t)
  `CACHE_TYPEDEF_AR_CHAN_T(slv_ar_chan_t, def_addr_t, def_slv_id_t, def_user_t)
  `CACHE_TYPEDEF_R_CHAN_T(mst_r_chan_t, def_data_t, def_mst_id_t, def_user_t)
  `CACHE_TYPEDEF_R_CHAN_T(slv_r_chan_t, def_data_t, def_slv_id_t, def_user_t)

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester at or after the pointer wins, pointer moves past it.
// ahead_free[i] says no requester precedes i in this cycle's scan order.
module rr_arbiter
  import cache_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = idx_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic [N-1:0]     ahead_free
);

  logic [IDX_W-1:0] ptr_reg, ptr_next;

  always_ff @(posedge clk) begin
    if (rst) ptr_reg <= '0;
    else     ptr_reg <= ptr_next;
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (advance && gnt_valid)
      ptr_next = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + IDX_W'(1);
  end

  always_comb begin
    int j;
    j          = 0;
    gnt        = '0;
    gnt_idx    = '0;
    gnt_valid  = 1'b0;
    ahead_free = '0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_reg) + k) % N;
      ahead_free[j] = !gnt_valid;
      if (!gnt_valid && req[j]) begin
        gnt[j]    = 1'b1;
        gnt_idx   = IDX_W'(j);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_rd_arbiter.sv
// N-to-1 CacheBus read arbiter: round-robin AR grant into a one-entry slice,
// R beats steered back by the master index carried in the upper ID bits.
module cache_rd_arbiter
  import cache_arb_pkg::*;
#(
  parameter int  N_MST           = 2,
  parameter int  ADDR_WIDTH      = 32,
  parameter int  DATA_WIDTH      = 64,
  parameter int  ID_WIDTH        = 4,
  parameter int  USER_WIDTH      = 1,
  parameter int  MAX_OUTSTANDING = 4,
  parameter int  IDX_W           = idx_w(N_MST),
  parameter type mst_ar_chan_t   = cache_arb_pkg::mst_ar_chan_t,
  parameter type mst_r_chan_t    = cache_arb_pkg::mst_r_chan_t,
  parameter type slv_ar_chan_t   = cache_arb_pkg::slv_ar_chan_t,
  parameter type slv_r_chan_t    = cache_arb_pkg::slv_r_chan_t
) (
  input  logic               clk,
  input  logic               rst,
  input  mst_ar_chan_t       m_ar_i       [N_MST],
  input  logic [N_MST-1:0]   m_ar_valid_i,
  output logic [N_MST-1:0]   m_ar_ready_o,
  output mst_r_chan_t        m_r_o        [N_MST],
  output logic [N_MST-1:0]   m_r_valid_o,
  input  logic [N_MST-1:0]   m_r_ready_i,
  output slv_ar_chan_t       s_ar_o,
  output logic               s_ar_valid_o,
  input  logic               s_ar_ready_i,
  input  slv_r_chan_t        s_r_i,
  input  logic               s_r_valid_i,
  output logic               s_r_ready_o,
  output logic               err_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef logic [ADDR_WIDTH-1:0]       addr_t;
  typedef logic [DATA_WIDTH-1:0]       data_t;
  typedef logic [ID_WIDTH-1:0]         id_t;
  typedef logic [ID_WIDTH+IDX_W-1:0]   slv_id_t;
  typedef logic [USER_WIDTH-1:0]       user_t;
  `CACHE_TYPEDEF_AR_CHAN_T(slice_t, addr_t, slv_id_t, user_t)
  `CACHE_TYPEDEF_R_CHAN_T(rbeat_t, data_t, id_t, user_t)

  logic [N_MST-1:0] eligible, cnt_ok, gnt, ahead_free, inc, dec, underflow;
  logic [IDX_W-1:0] gnt_idx, r_idx;
  logic             gnt_valid, load, ar_hs, r_ok;
  logic             slice_full_reg, err_reg, err_next;
  slice_t           slice_reg, slice_next;
  rbeat_t           r_beat;
  logic [CNT_W-1:0] cnt_reg [N_MST];

  // The slice can take a new entry when empty or when its current one leaves this cycle.
  assign load  = !slice_full_reg || s_ar_ready_i;
  assign ar_hs = !rst && load && gnt_valid;

  rr_arbiter #(.N(N_MST), .IDX_W(IDX_W)) u_rr (
    .clk        (clk),
    .rst        (rst),
    .req        (eligible),
    .advance    (ar_hs),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx),
    .gnt_valid  (gnt_valid),
    .ahead_free (ahead_free)
  );

  always_comb begin
    slice_next       = slice_reg;
    slice_next.id    = {gnt_idx, m_ar_i[gnt_idx].id};
    slice_next.addr  = m_ar_i[gnt_idx].addr;
    slice_next.len   = m_ar_i[gnt_idx].len;
    slice_next.size  = m_ar_i[gnt_idx].size;
    slice_next.burst = m_ar_i[gnt_idx].burst;
    slice_next.user  = m_ar_i[gnt_idx].user;
    slice_next.snoop = m_ar_i[gnt_idx].snoop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slice_full_reg <= 1'b0;
    end else if (load) begin
      slice_full_reg <= ar_hs;
      if (ar_hs) slice_reg <= slice_next;
    end
  end

  assign s_ar_o       = slice_reg;
  assign s_ar_valid_o = slice_full_reg;

  assign r_idx = s_r_i.id[ID_WIDTH +: IDX_W];
  if ((1 << IDX_W) > N_MST) begin : g_route_chk
    assign r_ok = int'(r_idx) < N_MST;
  end else begin : g_route_all
    assign r_ok = 1'b1;
  end

  always_comb begin
    r_beat      = '0;
    r_beat.id   = s_r_i.id[ID_WIDTH-1:0];
    r_beat.data = s_r_i.data;
    r_beat.resp = s_r_i.resp;
    r_beat.last = s_r_i.last;
    r_beat.user = s_r_i.user;
  end

  // Misrouted beats are sunk so the downstream port never stalls on them.
  assign s_r_ready_o = r_ok ? m_r_ready_i[r_idx] : 1'b1;

  // Ready is a function of pointer, other masters and own credit, never of own valid.
  for (genvar gi = 0; gi < N_MST; gi++) begin : g_mst
    assign cnt_ok[gi]       = cnt_reg[gi] < CNT_W'(MAX_OUTSTANDING);
    assign eligible[gi]     = m_ar_valid_i[gi] && cnt_ok[gi];
    assign m_ar_ready_o[gi] = !rst && load && ahead_free[gi] && cnt_ok[gi];
    assign inc[gi]          = ar_hs && gnt[gi];
    assign m_r_valid_o[gi]  = !rst && s_r_valid_i && r_ok && (int'(r_idx) == gi);
    assign m_r_o[gi]        = r_beat;
    assign dec[gi]          = m_r_valid_o[gi] && m_r_ready_i[gi] && s_r_i.last;
    assign underflow[gi]    = dec[gi] && !inc[gi] && (cnt_reg[gi] == '0);

    always_ff @(posedge clk) begin
      if (rst)
        cnt_reg[gi] <= '0;
      else if (inc[gi] && !dec[gi])
        cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
      else if (dec[gi] && !inc[gi] && cnt_reg[gi] != '0)
        cnt_reg[gi] <= cnt_reg[gi] - CNT_W'(1);
    end
  end

  assign err_next = err_reg || (|underflow) || (s_r_valid_i && !r_ok);

  always_ff @(posedge clk) begin
    if (rst) err_reg <= 1'b0;
    else     err_reg <= err_next;
  end

  assign err_o = err_reg;

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Randomized bench for cache_rd_arbiter (3 masters, 2 outstanding) against a
// transaction-level model, followed by directed reset, underflow and bad-route steps.
module tb_cache_rd_arbiter;

  localparam int N    = 3;
  localparam int MAXO = 2;

  typedef struct packed {
    logic [3:0] id; logic [31:0] addr; logic [7:0] len; logic [2:0] size;
    logic [1:0] burst; logic [0:0] user; logic [3:0] snoop;
  } mst_ar_t;
  typedef struct packed {
    logic [5:0] id; logic [31:0] addr; logic [7:0] len; logic [2:0] size;
    logic [1:0] burst; logic [0:0] user; logic [3:0] snoop;
  } slv_ar_t;
  typedef struct packed {
    logic [3:0] id; logic [63:0] data; logic [3:0] resp; logic last; logic [0:0] user;
  } mst_r_t;
  typedef struct packed {
    logic [5:0] id; logic [63:0] data; logic [3:0] resp; logic last; logic [0:0] user;
  } slv_r_t;
  typedef struct { logic [5:0] id; int beats; } pend_t;

  logic           clk = 1'b0;
  logic           rst;
  mst_ar_t        m_ar [N];
  logic [N-1:0]   m_ar_valid, m_ar_ready;
  mst_r_t         m_r [N];
  logic [N-1:0]   m_r_valid, m_r_ready;
  slv_ar_t        s_ar;
  logic           s_ar_valid, s_ar_ready;
  slv_r_t         s_r;
  logic           s_r_valid, s_r_ready, err;

  cache_rd_arbiter #(
    .N_MST(N), .ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4), .USER_WIDTH(1),
    .MAX_OUTSTANDING(MAXO),
    .mst_ar_chan_t(mst_ar_t), .mst_r_chan_t(mst_r_t),
    .slv_ar_chan_t(slv_ar_t), .slv_r_chan_t(slv_r_t)
  ) dut (
    .clk(clk), .rst(rst),
    .m_ar_i(m_ar), .m_ar_valid_i(m_ar_valid), .m_ar_ready_o(m_ar_ready),
    .m_r_o(m_r), .m_r_valid_o(m_r_valid), .m_r_ready_i(m_r_ready),
    .s_ar_o(s_ar), .s_ar_valid_o(s_ar_valid), .s_ar_ready_i(s_ar_ready),
    .s_r_i(s_r), .s_r_valid_i(s_r_valid), .s_r_ready_o(s_r_ready),
    .err_o(err)
  );

  always #5 clk = ~clk;

  int      n_vec = 0;
  int      n_err = 0;
  int      cnt_m [N];
  int      ptr_m;
  bit      full_m, err_m, rcur;
  int      rsel;
  slv_ar_t slice_m;
  pend_t   pend [$];
  logic [N-1:0] ar_done;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Spec rule: first master at or after the pointer with valid and spare credit.
  function automatic int rr_pick();
    int j;
    for (int k = 0; k < N; k++) begin
      j = (ptr_m + k) % N;
      if (m_ar_valid[j] && cnt_m[j] < MAXO) return j;
    end
    return -1;
  endfunction

  function automatic slv_ar_t exp_slice(input int w);
    slv_ar_t s;
    s.id    = {2'(w), m_ar[w].id};
    s.addr  = m_ar[w].addr;
    s.len   = m_ar[w].len;
    s.size  = m_ar[w].size;
    s.burst = m_ar[w].burst;
    s.user  = m_ar[w].user;
    s.snoop = m_ar[w].snoop;
    return s;
  endfunction

  task automatic idle_inputs();
    for (int i = 0; i < N; i++) m_ar[i] = '0;
    m_ar_valid = '0; m_r_ready = '0; s_ar_ready = 1'b0;
    s_r = '0; s_r_valid = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) cnt_m[i] = 0;
    ptr_m = 0; full_m = 1'b0; err_m = 1'b0; rcur = 1'b0; rsel = 0;
    ar_done = '0; pend.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; idle_inputs();
    @(posedge clk); @(negedge clk);
    rst = 1'b0; model_reset();
  endtask

  // One random cycle: drive at negedge, check at negedge+1, advance model at posedge.
  task automatic step();
    int w, idx;
    bit load, ar_hs, sar_hs, r_hs;
    mst_r_t er;
    for (int i = 0; i < N; i++) if (ar_done[i]) m_ar_valid[i] = 1'b0;
    ar_done = '0;
    for (int i = 0; i < N; i++) begin
      if (!m_ar_valid[i] && $urandom_range(0, 99) < 70) begin
        m_ar[i].id    = 4'($urandom);
        m_ar[i].addr  = $urandom;
        m_ar[i].len   = 8'($urandom_range(0, 3));
        m_ar[i].size  = 3'($urandom);
        m_ar[i].burst = 2'($urandom);
        m_ar[i].user  = 1'($urandom);
        m_ar[i].snoop = 4'($urandom);
        m_ar_valid[i] = 1'b1;
      end
    end
    s_ar_ready = ($urandom_range(0, 99) < 70);
    if (!rcur && pend.size() > 0 && $urandom_range(0, 99) < 60) begin
      rsel       = $urandom_range(0, pend.size() - 1);
      s_r.id     = pend[rsel].id;
      s_r.data   = {$urandom, $urandom};
      s_r.resp   = 4'($urandom);
      s_r.user   = 1'($urandom);
      s_r.last   = (pend[rsel].beats == 1);
      rcur       = 1'b1;
    end
    s_r_valid = rcur;
    m_r_ready = 3'($urandom);
    #1;
    load = !full_m || s_ar_ready;
    w    = rr_pick();
    for (int i = 0; i < N; i++)
      if (m_ar_valid[i]) check($sformatf("ar_ready%0d", i), m_ar_ready[i], load && (w == i));
    check("s_ar_valid", s_ar_valid, full_m);
    if (full_m) check("s_ar_payload", s_ar, slice_m);
    check("err_clean", err, err_m);
    r_hs = 1'b0; idx = 0;
    if (s_r_valid) begin
      idx = int'(s_r.id[5:4]);
      er  = '{id: s_r.id[3:0], data: s_r.data, resp: s_r.resp, last: s_r.last, user: s_r.user};
      for (int k = 0; k < N; k++)
        check($sformatf("r_valid%0d", k), m_r_valid[k], k == idx);
      check($sformatf("r_payload%0d", idx), m_r[idx], er);
      check("s_r_ready", s_r_ready, m_r_ready[idx]);
      r_hs = m_r_ready[idx];
    end else begin
      check("r_valid_idle", m_r_valid, '0);
    end
    ar_hs  = load && (w >= 0);
    sar_hs = full_m && s_ar_ready;
    @(posedge clk);
    if (sar_hs) pend.push_back('{slice_m.id, int'(slice_m.len) + 1});
    if (ar_hs) begin
      slice_m = exp_slice(w);
      full_m  = 1'b1;
      cnt_m[w]++;
      ptr_m   = (w + 1) % N;
      ar_done[w] = 1'b1;
    end else if (load) begin
      full_m = 1'b0;
    end
    if (r_hs) begin
      pend[rsel].beats--;
      if (s_r.last) begin
        cnt_m[idx]--;
        pend.delete(rsel);
      end
      rcur = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; idle_inputs(); model_reset();
    @(negedge clk);
    for (int i = 0; i < N; i++) m_ar[i].id = 4'(i + 1);
    m_ar_valid = '1; s_ar_ready = 1'b1; m_r_ready = '1;
    s_r.id = 6'b00_0001; s_r.last = 1'b1; s_r_valid = 1'b1;
    #1;
    check("rst_ar_ready", m_ar_ready, '0);
    check("rst_r_valid", m_r_valid, '0);
    @(negedge clk);
    rst = 1'b0; idle_inputs(); model_reset();
    #1;
    check("rst_s_ar_valid", s_ar_valid, 1'b0);
    check("rst_err", err, 1'b0);
    @(negedge clk);

    repeat (1500) step();

    // Last beat to a master with nothing outstanding.
    do_reset();
    s_r.id = 6'b00_0101; s_r.last = 1'b1; s_r_valid = 1'b1; m_r_ready = '1;
    #1;
    check("uf_r_valid", m_r_valid, 3'b001);
    check("uf_s_r_ready", s_r_ready, 1'b1);
    check("uf_err_before", err, 1'b0);
    @(negedge clk);
    s_r_valid = 1'b0;
    #1;
    check("uf_err_after", err, 1'b1);
    @(negedge clk);

    // Index 3 has no master behind it.
    do_reset();
    #1;
    check("bad_err_clear", err, 1'b0);
    s_r.id = 6'b11_0010; s_r.last = 1'b0; s_r_valid = 1'b1; m_r_ready = '0;
    #1;
    check("bad_s_r_ready", s_r_ready, 1'b1);
    check("bad_r_valid", m_r_valid, '0);
    check("bad_err_before", err, 1'b0);
    @(negedge clk);
    s_r_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("bad_err_sticky%0d", c), err, 1'b1);
      @(negedge clk);
    end
    do_reset();
    #1;
    check("bad_err_rst", err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
